// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Module : ps2_pkg
// Brief  : Shared scan-code constants and frame FSM state for the PS/2 path.
// Rev    : 1.0
// ============================================================================
package ps2_pkg;

  localparam logic [7:0] PS2_EXT_PREFIX   = 8'hE0;
  localparam logic [7:0] PS2_BREAK_PREFIX = 8'hF0;
  localparam logic [7:0] PS2_LSHIFT       = 8'h12;
  localparam logic [7:0] PS2_RSHIFT       = 8'h59;
  localparam logic [7:0] PS2_CAPS         = 8'h58;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } frame_state_e;

  // Odd parity: data bits plus parity bit must hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_line_sync.sv
`default_nettype none
// ============================================================================
// Module : ps2_line_sync
// Brief  : 2-flop synchronisers, FILTER_LEN clock filter, falling-edge strobe.
// Rev    : 1.0
// ============================================================================
module ps2_line_sync #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic sample_stb,
  output logic data_s
);

  localparam int               CNT_W    = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

  logic             clk_meta_q, clk_sync_q;
  logic             data_meta_q, data_sync_q;
  logic             clk_filt_q, clk_filt_d;
  logic [CNT_W-1:0] flt_cnt_q, flt_cnt_d;
  logic             stb_q, stb_d;

  // Counts consecutive samples disagreeing with the filtered level; any
  // agreeing sample restarts the count, so short glitches never get through.
  always_comb begin
    clk_filt_d = clk_filt_q;
    flt_cnt_d  = '0;
    if (clk_sync_q != clk_filt_q) begin
      if (flt_cnt_q == CNT_LAST) begin
        clk_filt_d = clk_sync_q;
      end else begin
        flt_cnt_d = flt_cnt_q + 1'b1;
      end
    end
    stb_d = clk_filt_q & ~clk_filt_d;
  end

  // Line flops reset to the idle-high bus level so reset never fakes an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
      clk_filt_q  <= 1'b1;
      flt_cnt_q   <= '0;
      stb_q       <= 1'b0;
    end else begin
      clk_meta_q  <= ps2_clk;
      clk_sync_q  <= clk_meta_q;
      data_meta_q <= ps2_data;
      data_sync_q <= data_meta_q;
      clk_filt_q  <= clk_filt_d;
      flt_cnt_q   <= flt_cnt_d;
      stb_q       <= stb_d;
    end
  end

  assign sample_stb = stb_q;
  assign data_s     = data_sync_q;

endmodule
`default_nettype wire

// File: rtl/ps2_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module : ps2_scan_decoder
// Brief  : PS/2 frame receiver with E0/F0 prefix folding and Shift tracking.
//          Optional PS2_CAPS_LOCK_EN adds a Caps Lock toggle on make of 0x58.
// Rev    : 1.0
// ============================================================================
module ps2_scan_decoder
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 10000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] scan_code,
  output logic       extended,
  output logic       shift_mode,
  output logic       key_valid,
  output logic       frame_err
);

  localparam int            TO_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic sample_stb;
  logic data_s;

  ps2_line_sync #(
    .FILTER_LEN (FILTER_LEN)
  ) u_line_sync (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .sample_stb (sample_stb),
    .data_s     (data_s)
  );

  frame_state_e    state_q, state_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            parity_q, parity_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic [7:0]      rx_byte_q, rx_byte_d;
  logic            rx_good_q, rx_good_d;
  logic            rx_err_q, rx_err_d;

  // Frame FSM; a received byte or error is handed to the prefix stage one
  // cycle later, so both outputs leave from the same pipeline stage.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    parity_d  = parity_q;
    rx_byte_d = rx_byte_q;
    rx_good_d = 1'b0;
    rx_err_d  = 1'b0;
    to_cnt_d  = (state_q == ST_IDLE) ? '0 : to_cnt_q + 1'b1;

    if (sample_stb) begin
      to_cnt_d = '0;
      case (state_q)
        ST_IDLE: begin
          if (!data_s) begin
            state_d   = ST_DATA;
            bit_cnt_d = 3'd0;
          end
        end
        ST_DATA: begin
          shreg_d   = {data_s, shreg_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) begin
            state_d = ST_PARITY;
          end
        end
        ST_PARITY: begin
          parity_d = data_s;
          state_d  = ST_STOP;
        end
        ST_STOP: begin
          state_d = ST_IDLE;
          if (data_s && odd_parity_ok(shreg_q, parity_q)) begin
            rx_good_d = 1'b1;
            rx_byte_d = shreg_q;
          end else begin
            rx_err_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if ((state_q != ST_IDLE) && (to_cnt_q == TO_LAST)) begin
      state_d  = ST_IDLE;
      to_cnt_d = '0;
      rx_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      parity_q  <= 1'b0;
      to_cnt_q  <= '0;
      rx_byte_q <= '0;
      rx_good_q <= 1'b0;
      rx_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      parity_q  <= parity_d;
      to_cnt_q  <= to_cnt_d;
      rx_byte_q <= rx_byte_d;
      rx_good_q <= rx_good_d;
      rx_err_q  <= rx_err_d;
    end
  end

  logic       ext_pend_q, ext_pend_d;
  logic       brk_pend_q, brk_pend_d;
  logic       lshift_held_q, lshift_held_d;
  logic       rshift_held_q, rshift_held_d;
  logic [7:0] scan_code_q, scan_code_d;
  logic       extended_q, extended_d;
  logic       shift_mode_q, shift_mode_d;
  logic       key_valid_q, key_valid_d;
  logic       frame_err_q, frame_err_d;
  logic       shift_now;
  logic       is_shift_code;

`ifdef PS2_CAPS_LOCK_EN
  logic       caps_lock_q, caps_lock_d;
  assign shift_now = (lshift_held_q | rshift_held_q) ^ caps_lock_q;
`else
  assign shift_now = lshift_held_q | rshift_held_q;
`endif

  assign is_shift_code = (rx_byte_q == PS2_LSHIFT) || (rx_byte_q == PS2_RSHIFT);

  always_comb begin
    ext_pend_d    = ext_pend_q;
    brk_pend_d    = brk_pend_q;
    lshift_held_d = lshift_held_q;
    rshift_held_d = rshift_held_q;
    scan_code_d   = scan_code_q;
    extended_d    = extended_q;
    shift_mode_d  = shift_mode_q;
    key_valid_d   = 1'b0;
    frame_err_d   = 1'b0;
`ifdef PS2_CAPS_LOCK_EN
    caps_lock_d   = caps_lock_q;
`endif

    if (rx_err_q) begin
      frame_err_d = 1'b1;
      ext_pend_d  = 1'b0;
      brk_pend_d  = 1'b0;
    end else if (rx_good_q) begin
      if (rx_byte_q == PS2_EXT_PREFIX) begin
        ext_pend_d = 1'b1;
      end else if (rx_byte_q == PS2_BREAK_PREFIX) begin
        brk_pend_d = 1'b1;
      end else begin
        ext_pend_d = 1'b0;
        brk_pend_d = 1'b0;
        // E0-prefixed Shift codes are the fake shifts some keyboards emit.
        if (is_shift_code) begin
          if (!ext_pend_q) begin
            if (rx_byte_q == PS2_LSHIFT) begin
              lshift_held_d = ~brk_pend_q;
            end else begin
              rshift_held_d = ~brk_pend_q;
            end
          end
`ifdef PS2_CAPS_LOCK_EN
        end else if ((rx_byte_q == PS2_CAPS) && !ext_pend_q) begin
          if (!brk_pend_q) begin
            caps_lock_d = ~caps_lock_q;
          end
`endif
        end else if (!brk_pend_q) begin
          key_valid_d  = 1'b1;
          scan_code_d  = rx_byte_q;
          extended_d   = ext_pend_q;
          shift_mode_d = shift_now;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ext_pend_q    <= 1'b0;
      brk_pend_q    <= 1'b0;
      lshift_held_q <= 1'b0;
      rshift_held_q <= 1'b0;
      scan_code_q   <= '0;
      extended_q    <= 1'b0;
      shift_mode_q  <= 1'b0;
      key_valid_q   <= 1'b0;
      frame_err_q   <= 1'b0;
`ifdef PS2_CAPS_LOCK_EN
      caps_lock_q   <= 1'b0;
`endif
    end else begin
      ext_pend_q    <= ext_pend_d;
      brk_pend_q    <= brk_pend_d;
      lshift_held_q <= lshift_held_d;
      rshift_held_q <= rshift_held_d;
      scan_code_q   <= scan_code_d;
      extended_q    <= extended_d;
      shift_mode_q  <= shift_mode_d;
      key_valid_q   <= key_valid_d;
      frame_err_q   <= frame_err_d;
`ifdef PS2_CAPS_LOCK_EN
      caps_lock_q   <= caps_lock_d;
`endif
    end
  end

  assign scan_code  = scan_code_q;
  assign extended   = extended_q;
  assign shift_mode = shift_mode_q;
  assign key_valid  = key_valid_q;
  assign frame_err  = frame_err_q;

endmodule
`default_nettype wire
